proc_run_ctrl: RTL

- Sequencer for the SingleCycleProc core.
- On a start request it latches a program entry PC and holds the core in reset for a fixed number of cycles. It then releases the core and lets it run for a programmed cycle budget.
- Afterwards it samples dMemOut on N consecutive cycles and checks each sample against a stream of expected words.
- It produces pass/fail counts and a done pulse, replacing hand-timed reset/run/check sequencing.

---
 rtl/proc_ctrl_pkg.sv | 18 +
 rtl/proc_cycle_counter.sv | 28 ++
 rtl/proc_run_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared types and default sizing for the run sequencer.
package proc_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        SAMPLE,
        DONE
    } state_t;

    localparam int unsigned DEF_RST_CYCLES = 1;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_SAMP_W     = 8;

endpackage

// File: rtl/proc_cycle_counter.sv
// Loadable down-counter that stops at zero and flags it.
module proc_cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; decrement holds once zero is reached.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/proc_run_ctrl.sv
// Reset/run/check sequencer for the SingleCycleProc core.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SAMP_W     = DEF_SAMP_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [31:0]       prog_pc,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic [SAMP_W-1:0] num_samples,
    input  logic              exp_valid,
    input  logic [31:0]       exp_data,
    output logic              exp_ready,
    input  logic [31:0]       dMemOut,
    output logic              proc_reset_l,
    output logic [31:0]       proc_start_pc,
    output logic              busy,
    output logic              done,
    output logic [SAMP_W-1:0] pass_count,
    output logic [SAMP_W-1:0] fail_count,
    output logic              all_passed,
    output logic              mismatch,
    output word_t             mismatch_data,
    output logic              underrun
);

    state_t            state;
    logic [CNT_W-1:0]  run_len;
    logic [SAMP_W-1:0] samp_len;
    logic              ph_zero;
    logic              sm_zero;
    logic              start_acc;
    logic              run_over;
    logic              enter_run;
    logic              enter_sample;
    logic              go_done;
    logic              ph_load;
    logic              ph_dec;
    logic [CNT_W-1:0]  ph_val;
    logic              hit;
    logic [SAMP_W-1:0] pass_nxt;
    logic [SAMP_W-1:0] fail_nxt;

    // Counters hold "cycles remaining minus one", so a phase ends on the cycle its counter reads zero.
    always_comb begin
        start_acc    = (state == IDLE) && start;
        run_over     = ((state == RESET) && ph_zero && (run_len == '0)) ||
                       ((state == RUN) && ph_zero);
        enter_run    = (state == RESET) && ph_zero && (run_len != '0);
        enter_sample = run_over && (samp_len != '0);
        go_done      = (run_over && (samp_len == '0)) || ((state == SAMPLE) && sm_zero);
        ph_load      = start_acc || enter_run;
        ph_dec       = (state == RESET) || (state == RUN);
        ph_val       = enter_run ? (run_len - 1'b1) : CNT_W'(RST_CYCLES - 1);
        hit          = exp_valid && (dMemOut == exp_data);
        pass_nxt     = pass_count;
        fail_nxt     = fail_count;
        if (state == SAMPLE) begin
            if (hit) begin
                if (pass_count != '1) pass_nxt = pass_count + 1'b1;
            end else begin
                if (fail_count != '1) fail_nxt = fail_count + 1'b1;
            end
        end
    end

    proc_cycle_counter #(.W(CNT_W)) u_phase_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    proc_cycle_counter #(.W(SAMP_W)) u_sample_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (enter_sample),
        .load_val (samp_len - 1'b1),
        .dec      (state == SAMPLE),
        .zero     (sm_zero)
    );

    // Sequencer state and all registered outputs; DONE entry is shared by three paths, so it is applied last.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            run_len       <= '0;
            samp_len      <= '0;
            proc_reset_l  <= 1'b0;
            proc_start_pc <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            exp_ready     <= 1'b0;
            mismatch      <= 1'b0;
            underrun      <= 1'b0;
            pass_count    <= '0;
            fail_count    <= '0;
            all_passed    <= 1'b0;
            mismatch_data <= '0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    proc_reset_l <= 1'b0;
                    if (start) begin
                        proc_start_pc <= prog_pc;
                        run_len       <= run_cycles;
                        samp_len      <= num_samples;
                        pass_count    <= '0;
                        fail_count    <= '0;
                        underrun      <= 1'b0;
                        all_passed    <= 1'b0;
                        busy          <= 1'b1;
                        state         <= RESET;
                    end
                end
                RESET, RUN: begin
                    if (enter_run) begin
                        state        <= RUN;
                        proc_reset_l <= 1'b1;
                    end else if (enter_sample) begin
                        state        <= SAMPLE;
                        proc_reset_l <= 1'b1;
                        exp_ready    <= 1'b1;
                    end
                end
                SAMPLE: begin
                    pass_count <= pass_nxt;
                    fail_count <= fail_nxt;
                    if (!exp_valid) begin
                        underrun <= 1'b1;
                    end else if (!hit) begin
                        mismatch      <= 1'b1;
                        mismatch_data <= dMemOut;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (go_done) begin
                state        <= DONE;
                done         <= 1'b1;
                busy         <= 1'b0;
                exp_ready    <= 1'b0;
                proc_reset_l <= 1'b0;
                all_passed   <= (pass_nxt == samp_len);
            end
        end
    end

endmodule
